// File: rtl/spi_reg_bank.sv
`timescale 1ns/1ps
// spi_reg_bank: register bank and command decoder that sits downstream of spi_slave.
// Each SPI transaction, framed by ss, is a command frame followed by data frames:
//   - The command frame carries the direction in bit WIDTH-1 (1 = write) and the start
//     address in bits [ADDRW-1:0].
//   - A write transaction stores each following frame and auto-increments the address.
//   - A read transaction returns reg[ptr] through tx_buffer/wr, one frame after each
//     received frame, and also auto-increments.
// A local core port gives direct access to the same registers. When both ports write
// the same address in the same cycle, the SPI write wins.
//
// Ports:
//   clk, rst            system clock, asynchronous active-low reset
//   ss                  SPI slave select (active low, asynchronous to clk)
//   rx_buffer, rx_dv    received frame and its one-cycle valid pulse
//   tx_buffer, wr       next frame to shift out and its one-cycle load pulse
//   busy                high while a transaction is open
//   core_addr/wdata/we  core write port
//   core_rdata          combinational reg[core_addr]
module spi_reg_bank #(
  parameter int WIDTH = 8,
  parameter int ADDRW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ss,
  input  logic [WIDTH-1:0] rx_buffer,
  input  logic             rx_dv,
  output logic [WIDTH-1:0] tx_buffer,
  output logic             wr,
  output logic             busy,
  input  logic [ADDRW-1:0] core_addr,
  input  logic [WIDTH-1:0] core_wdata,
  input  logic             core_we,
  output logic [WIDTH-1:0] core_rdata
);

  localparam int NREGS = 2 ** ADDRW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_WRITE,
    S_READ
  } state_e;

  state_e           state_q, state_d;
  logic [ADDRW-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0] tx_buffer_q, tx_buffer_d;
  logic             wr_q, wr_d;
  logic             busy_q, busy_d;
  logic             ss_meta_q, ss_sync_q;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic             spi_we;

  // Two-flop synchronizer for ss. Both flops reset to the deselected level so that
  // leaving reset never looks like the start of a transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ss_meta_q <= 1'b1;
      ss_sync_q <= 1'b1;
    end else begin
      ss_meta_q <= ss;
      ss_sync_q <= ss_meta_q;
    end
  end

  // Command decoder. Read data is fetched using the post-increment pointer, so
  // tx_buffer and wr both become valid in the cycle right after rx_dv.
  always_comb begin
    // NOTE: every signal gets a default first, so no path can leave one unassigned
    // and infer a latch.
    state_d     = state_q;
    ptr_d       = ptr_q;
    tx_buffer_d = tx_buffer_q;
    wr_d        = 1'b0;
    spi_we      = 1'b0;
    if (ss_sync_q) begin
      // Deselect abandons any open transaction. rx_dv is ignored here.
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_CMD;
        S_CMD: begin
          if (rx_dv) begin
            ptr_d = rx_buffer[ADDRW-1:0];
            if (rx_buffer[WIDTH-1]) begin
              state_d = S_WRITE;
            end else begin
              state_d     = S_READ;
              wr_d        = 1'b1;
              tx_buffer_d = regs_q[ptr_d];
            end
          end
        end
        S_WRITE: begin
          if (rx_dv) begin
            spi_we = 1'b1;
            ptr_d  = ADDRW'(ptr_q + 1'b1);
          end
        end
        S_READ: begin
          if (rx_dv) begin
            ptr_d       = ADDRW'(ptr_q + 1'b1);
            wr_d        = 1'b1;
            tx_buffer_d = regs_q[ptr_d];
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  // Register file next state: the SPI write has priority on an address collision.
  // Writes to different addresses in the same cycle both land.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (spi_we && (ptr_q == ADDRW'(i))) begin
        regs_d[i] = rx_buffer;
      end else if (core_we && (core_addr == ADDRW'(i))) begin
        regs_d[i] = core_wdata;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      tx_buffer_q <= '0;
      wr_q        <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      tx_buffer_q <= tx_buffer_d;
      wr_q        <= wr_d;
      busy_q      <= busy_d;
    end
  end

  // NOTE: the register file is reset explicitly, because registers must read 0
  // after reset. This rules out a RAM macro, which is acceptable for a small bank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign tx_buffer  = tx_buffer_q;
  assign wr         = wr_q;
  assign busy       = busy_q;
  assign core_rdata = regs_q[core_addr];

endmodule

// File: tb/tb_spi_reg_bank.sv
`timescale 1ns/1ps
// Testbench for spi_reg_bank. Each read frame sent by the stimulus pushes its
// expected tx_buffer value into a scoreboard queue. A monitor pops from the queue on
// every wr pulse and compares. Register contents and busy are checked directly
// against hand-computed constants.
module tb_spi_reg_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ss = 1'b1;
  logic [7:0] rx_buffer = '0;
  logic       rx_dv = 1'b0;
  logic [7:0] tx_buffer;
  logic       wr;
  logic       busy;
  logic [3:0] core_addr = '0;
  logic [7:0] core_wdata = '0;
  logic       core_we = 1'b0;
  logic [7:0] core_rdata;

  int errors = 0;
  int checks = 0;
  int pushes = 0;
  int wr_pulses = 0;
  logic [7:0] sb_q[$];
  logic dv_at_edge = 1'b0;
  logic wr_prev = 1'b0;

  spi_reg_bank #(.WIDTH(8), .ADDRW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .ss         (ss),
    .rx_buffer  (rx_buffer),
    .rx_dv      (rx_dv),
    .tx_buffer  (tx_buffer),
    .wr         (wr),
    .busy       (busy),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_we    (core_we),
    .core_rdata (core_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor. rx_dv is sampled on the rising edge. Each wr is checked on the
  // following falling edge.
  always @(posedge clk) dv_at_edge <= rx_dv;

  always @(negedge clk) begin
    if (rst && wr) begin
      wr_pulses++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_unexpected: wr pulsed with tx_buffer=0x%0h, no read pending", tx_buffer);
      end else begin
        check("tx_buffer", int'(tx_buffer), int'(sb_q.pop_front()));
      end
      check("wr_latency", int'(dv_at_edge), 1);
      check("wr_single_cycle", int'(wr_prev), 0);
    end
    wr_prev <= rst && wr;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SPI frame, optionally with a core write in the same cycle. The frame is
  // followed by one idle cycle, so consecutive frames arrive at the tightest spacing.
  task automatic spi_frame(input logic [7:0] data, input bit cwe,
                           input logic [3:0] caddr, input logic [7:0] cdata);
    rx_buffer  = data;
    rx_dv      = 1'b1;
    core_we    = cwe;
    core_addr  = caddr;
    core_wdata = cdata;
    step(1);
    rx_dv   = 1'b0;
    core_we = 1'b0;
    step(1);
  endtask

  task automatic send(input logic [7:0] data);
    spi_frame(data, 1'b0, 4'd0, 8'd0);
  endtask

  task automatic expect_read(input logic [7:0] data);
    sb_q.push_back(data);
    pushes++;
  endtask

  task automatic core_write(input logic [3:0] a, input logic [7:0] d);
    core_addr  = a;
    core_wdata = d;
    core_we    = 1'b1;
    step(1);
    core_we = 1'b0;
  endtask

  task automatic core_check(input string name, input logic [3:0] a, input logic [7:0] d);
    core_addr = a;
    #1;
    check(name, int'(core_rdata), int'(d));
  endtask

  task automatic ss_low();
    ss = 1'b0;
    step(3);
    check("busy_rise", int'(busy), 1);
  endtask

  task automatic ss_high();
    ss = 1'b1;
    step(3);
    check("busy_fall", int'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    step(3);
    // Outputs while reset is held.
    check("rst_tx_buffer", int'(tx_buffer), 0);
    check("rst_wr", int'(wr), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b1;
    step(2);
    core_check("rst_reg0", 4'd0, 8'h00);
    core_check("rst_reg15", 4'd15, 8'h00);
    check("idle_busy", int'(busy), 0);

    // Write burst from address 3, then read back through the core port.
    ss_low();
    send(8'h83);
    send(8'hA5);
    send(8'h5A);
    ss_high();
    core_check("wr_reg3", 4'd3, 8'hA5);
    core_check("wr_reg4", 4'd4, 8'h5A);
    check("no_wr_in_write", wr_pulses, 0);

    // Read from 15, then wrap to 0.
    core_write(4'd15, 8'h11);
    core_write(4'd0, 8'h22);
    ss_low();
    expect_read(8'h11);
    send(8'h0F);
    expect_read(8'h22);
    send(8'h00);
    ss_high();

    // Same-address collision: the SPI write wins. A collision-free core write lands.
    ss_low();
    send(8'h82);
    spi_frame(8'h77, 1'b1, 4'd2, 8'h99);
    spi_frame(8'h3C, 1'b1, 4'd5, 8'h55);
    ss_high();
    core_check("collide_reg2", 4'd2, 8'h77);
    core_check("spi_reg3", 4'd3, 8'h3C);
    core_check("core_reg5", 4'd5, 8'h55);

    // Aborted write: frames received after deselect are ignored.
    core_write(4'd1, 8'hC3);
    ss_low();
    send(8'h81);
    ss = 1'b1;
    step(2);
    check("abort_busy_2cyc", int'(busy), 1);
    step(1);
    check("abort_busy_3cyc", int'(busy), 0);
    send(8'h33);
    core_check("abort_reg1", 4'd1, 8'hC3);
    ss_low();
    send(8'h81);
    send(8'h44);
    ss_high();
    core_check("recmd_reg1", 4'd1, 8'h44);

    // Reset in the middle of a read.
    core_write(4'd7, 8'h5C);
    ss_low();
    expect_read(8'h5C);
    send(8'h07);
    check("pre_rst_busy", int'(busy), 1);
    rst = 1'b0;
    ss  = 1'b1;
    #1;
    check("mid_rst_tx_buffer", int'(tx_buffer), 0);
    check("mid_rst_wr", int'(wr), 0);
    check("mid_rst_busy", int'(busy), 0);
    step(2);
    rst = 1'b1;
    step(4);
    check("post_rst_idle", int'(busy), 0);
    for (int i = 0; i < 16; i++) core_check("post_rst_reg", 4'(i), 8'h00);

    // Fresh read after reset: reg9, then reg10, which is still 0.
    core_write(4'd9, 8'h9A);
    ss_low();
    expect_read(8'h9A);
    send(8'h09);
    expect_read(8'h00);
    send(8'h55);
    ss_high();

    step(2);
    check("sb_empty", sb_q.size(), 0);
    check("wr_pulse_count", wr_pulses, pushes);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
